// File: rtl/timer_datapath_if.sv
// Control/status bundle between the timer front panel and the timer datapath.
// Pulse inputs are one-cycle strobes sampled on the rising clock edge; level inputs are plain levels.
interface timer_if;
  logic       run_stop;
  logic       clear;
  logic       down;
  logic       hour_up;
  logic       hour_down;
  logic       min_up;
  logic       min_down;
  logic       sec_up;
  logic       sec_down;
  logic       set_hour;
  logic       set_min;
  logic       set_sec;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       end_pulse;
  logic       blank_hour;
  logic       blank_min;
  logic       blank_sec;

  modport master (
    output run_stop, clear, down,
    output hour_up, hour_down, min_up, min_down, sec_up, sec_down,
    output set_hour, set_min, set_sec,
    input  hour, min, sec, end_pulse,
    input  blank_hour, blank_min, blank_sec
  );

  modport slave (
    input  run_stop, clear, down,
    input  hour_up, hour_down, min_up, min_down, sec_up, sec_down,
    input  set_hour, set_min, set_sec,
    output hour, min, sec, end_pulse,
    output blank_hour, blank_min, blank_sec
  );
endinterface

// File: rtl/timer_datapath.sv
// HH:MM:SS up/down timer: 1 s prescaler, field adjust while stopped, countdown end pulse
// and a blink phase used to flash the field currently being edited.
module timer_datapath #(
  parameter int P_TICK_DIV  = 100_000_000,
  parameter int P_BLINK_DIV = 50_000_000
) (
  input logic  iClk,
  input logic  iRst,
  timer_if.slave bus
);
  localparam int TW = (P_TICK_DIV  > 1) ? $clog2(P_TICK_DIV)  : 1;
  localparam int BW = (P_BLINK_DIV > 1) ? $clog2(P_BLINK_DIV) : 1;
  localparam logic [TW-1:0] PRESC_MAX = TW'(P_TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(P_BLINK_DIV - 1);

  logic [TW-1:0] presc_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          end_q, end_d;
  logic          tick;
  logic          adj_any;
  logic          time_zero;

  assign tick      = bus.run_stop && (presc_q == PRESC_MAX);
  assign adj_any   = bus.hour_up | bus.hour_down | bus.min_up |
                     bus.min_down | bus.sec_up | bus.sec_down;
  assign time_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      presc_q <= '0;
    end else if (bus.clear || !bus.run_stop || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Adjust and tick are mutually exclusive through run_stop; clear overrides both.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    end_d  = 1'b0;
    if (bus.clear) begin
      hour_d = 5'd0;
      min_d  = 6'd0;
      sec_d  = 6'd0;
    end else if (!bus.run_stop && adj_any) begin
      if (bus.sec_up && !bus.sec_down)        sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      else if (bus.sec_down && !bus.sec_up)   sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
      if (bus.min_up && !bus.min_down)        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      else if (bus.min_down && !bus.min_up)   min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      if (bus.hour_up && !bus.hour_down)      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      else if (bus.hour_down && !bus.hour_up) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
    end else if (tick) begin
      if (bus.down) begin
        // Result is zero when starting from 00:00:01 or when already parked at zero.
        end_d = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q <= 6'd1);
        if (!time_zero) begin
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            sec_d = 6'd59;
            if (min_q != 6'd0) begin
              min_d = min_q - 6'd1;
            end else begin
              min_d  = 6'd59;
              hour_d = hour_q - 5'd1;
            end
          end
        end
      end else begin
        if (sec_q != 6'd59) begin
          sec_d = sec_q + 6'd1;
        end else begin
          sec_d = 6'd0;
          if (min_q != 6'd59) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hour_q <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      end_q  <= 1'b0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      end_q  <= end_d;
    end
  end

  // Restarting the blink on any adjust makes the freshly edited field visible at once.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (adj_any) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  assign bus.hour       = hour_q;
  assign bus.min        = min_q;
  assign bus.sec        = sec_q;
  assign bus.end_pulse  = end_q;
  assign bus.blank_hour = bus.set_hour & blink_phase_q;
  assign bus.blank_min  = bus.set_min  & blink_phase_q;
  assign bus.blank_sec  = bus.set_sec  & blink_phase_q;
endmodule

// File: tb/tb_timer_datapath.sv
// Directed bench for timer_datapath with a small tick/blink divider; expected
// values are queued when stimulus is applied and popped at each check point.
module tb_timer_datapath;
  localparam int W = 18;
  localparam logic [5:0] HOUR_UP   = 6'b100000;
  localparam logic [5:0] HOUR_DOWN = 6'b010000;
  localparam logic [5:0] MIN_UP    = 6'b001000;
  localparam logic [5:0] MIN_DOWN  = 6'b000100;
  localparam logic [5:0] SEC_UP    = 6'b000010;
  localparam logic [5:0] SEC_DOWN  = 6'b000001;

  logic clk;
  logic rst;
  logic [W-1:0] exp_q[$];
  int compared;
  int mismatched;

  timer_if bus ();

  timer_datapath #(
    .P_TICK_DIV (4),
    .P_BLINK_DIV(8)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adjust(input logic [5:0] m);
    {bus.hour_up, bus.hour_down, bus.min_up, bus.min_down, bus.sec_up, bus.sec_down} = m;
    step(1);
    {bus.hour_up, bus.hour_down, bus.min_up, bus.min_down, bus.sec_up, bus.sec_down} = 6'b0;
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
  endtask

  // Scoreboard
  task automatic push_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input logic e);
    exp_q.push_back({e, h, m, s});
  endtask

  task automatic push_blank(input logic bh, input logic bm, input logic bs);
    exp_q.push_back({15'd0, bh, bm, bs});
  endtask

  task automatic check_time(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {bus.end_pulse, bus.hour, bus.min, bus.sec};
    exp = exp_q.pop_front();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed end=%0b %0d:%0d:%0d expected end=%0b %0d:%0d:%0d",
             tag, obs[17], obs[16:12], obs[11:6], obs[5:0],
             exp[17], exp[16:12], exp[11:6], exp[5:0]);
    end
  endtask

  task automatic check_blank(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {15'd0, bus.blank_hour, bus.blank_min, bus.blank_sec};
    exp = exp_q.pop_front();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed blank(h,m,s)=%b expected %b", tag, obs[2:0], exp[2:0]);
    end
  endtask

  // Stimulus
  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    {bus.run_stop, bus.clear, bus.down} = 3'b0;
    {bus.hour_up, bus.hour_down, bus.min_up, bus.min_down, bus.sec_up, bus.sec_down} = 6'b0;
    {bus.set_hour, bus.set_min, bus.set_sec} = 3'b0;
    #1 rst = 1'b1;
    #1;
    push_time(0, 0, 0, 0); check_time("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // Countdown 00:00:02 -> 00:00:00 with end pulse, then re-tick at zero
    adjust(SEC_UP); adjust(SEC_UP);
    push_time(0, 0, 2, 0); check_time("preload_2s");
    bus.down = 1'b1; bus.run_stop = 1'b1;
    push_time(0, 0, 1, 0); step(4); check_time("down_first_tick");
    push_time(0, 0, 0, 1); step(4); check_time("down_to_zero_end");
    push_time(0, 0, 0, 0); step(1); check_time("end_one_cycle");
    push_time(0, 0, 0, 1); step(3); check_time("zero_retick_end");
    bus.run_stop = 1'b0;
    push_time(0, 0, 0, 0); step(1); check_time("end_drops");

    // Borrow from minutes
    clear_pulse(); adjust(MIN_UP);
    push_time(0, 1, 0, 0); check_time("preload_1m");
    bus.run_stop = 1'b1;
    push_time(0, 0, 59, 0); step(4); check_time("borrow_min");
    bus.run_stop = 1'b0;

    // Field adjust wraps while idle
    clear_pulse();
    push_time(0, 0, 59, 0);   adjust(SEC_DOWN);  check_time("sec_down_wrap");
    push_time(0, 59, 59, 0);  adjust(MIN_DOWN);  check_time("min_down_wrap");
    push_time(23, 59, 59, 0); adjust(HOUR_DOWN); check_time("hour_down_wrap");
    push_time(0, 59, 59, 0);  adjust(HOUR_UP);   check_time("hour_up_wrap");
    push_time(23, 59, 59, 0); adjust(HOUR_DOWN); check_time("hour_down_again");

    // Count-up wrap 23:59:59 -> 00:00:00 without end; adjust ignored while running
    bus.down = 1'b0; bus.run_stop = 1'b1;
    push_time(0, 0, 0, 0); step(4); check_time("wrap_up_no_end");
    push_time(0, 0, 0, 0); adjust(SEC_UP); check_time("adjust_ignored_running");
    bus.run_stop = 1'b0;

    // Prescaler held at zero while stopped
    step(1);
    bus.run_stop = 1'b1; step(2);
    bus.run_stop = 1'b0; step(3);
    bus.run_stop = 1'b1;
    push_time(0, 0, 0, 0); step(3); check_time("presc_held");
    push_time(0, 0, 1, 0); step(1); check_time("presc_restart");
    bus.run_stop = 1'b0;

    // Up+down cancel, independent fields, sec/min up wrap without carry
    push_time(0, 0, 1, 0);  adjust(SEC_UP | SEC_DOWN); check_time("updown_cancel");
    push_time(1, 59, 2, 0); adjust(HOUR_UP | MIN_DOWN | SEC_UP); check_time("multi_field");
    clear_pulse(); adjust(SEC_DOWN);
    push_time(0, 0, 0, 0);  adjust(SEC_UP); check_time("sec_up_wrap_no_carry");
    adjust(MIN_DOWN);
    push_time(0, 0, 0, 0);  adjust(MIN_UP); check_time("min_up_wrap_no_carry");

    // Clear beats a coincident tick and min adjust
    repeat (5) adjust(MIN_UP);
    push_time(0, 5, 0, 0); check_time("preload_5m");
    bus.down = 1'b1; bus.run_stop = 1'b1;
    step(3);
    bus.clear = 1'b1; bus.min_up = 1'b1;
    step(1);
    bus.clear = 1'b0; bus.min_up = 1'b0;
    push_time(0, 0, 0, 0); check_time("clear_beats_tick");
    bus.run_stop = 1'b0;

    // Clear suppresses the end pulse of a 00:00:01 -> 00:00:00 tick
    clear_pulse(); adjust(SEC_UP);
    bus.run_stop = 1'b1;
    step(3);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    push_time(0, 0, 0, 0); check_time("clear_suppresses_end");
    bus.run_stop = 1'b0;

    // Asynchronous reset mid-count, then restart from a zeroed prescaler
    step(1);
    repeat (3) adjust(SEC_UP);
    bus.down = 1'b0; bus.run_stop = 1'b1;
    step(2);
    #2 rst = 1'b1;
    #1;
    push_time(0, 0, 0, 0); check_time("async_reset_midcount");
    @(posedge clk); #1;
    rst = 1'b0;
    push_time(0, 0, 0, 0); step(3); check_time("reset_no_early_tick");
    push_time(0, 0, 1, 0); step(1); check_time("reset_restart_tick");
    bus.run_stop = 1'b0;

    // Blink: edited field visible for 8 cycles after an adjust, then blanked
    bus.set_min = 1'b1;
    adjust(MIN_UP);
    for (int i = 0; i < 8; i++) begin
      push_blank(0, 0, 0); check_blank("blink_visible_after_adjust");
      if (i < 7) step(1);
    end
    step(1);
    push_blank(0, 1, 0); check_blank("blink_min_blanked");
    bus.set_hour = 1'b1;
    #1;
    push_blank(1, 1, 0); check_blank("blink_hour_follows_set");
    step(7);
    push_blank(1, 1, 0); check_blank("blink_phase_hold");
    step(1);
    push_blank(0, 0, 0); check_blank("blink_phase_toggle_back");
    bus.set_hour = 1'b0; bus.set_min = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
